multi_cycle_divider: RTL and testbench

//   Iterative radix-2 restoring divider: the inverse of the pipelined multiplier in the
//   CPU's MultiCycleAluOps group. Computes quotient and remainder for signed/unsigned DIV/MOD.

---
 rtl/multi_cycle_divider.sv | 96 +++++++++
 tb/tb_multi_cycle_divider.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/multi_cycle_divider.sv
// multi_cycle_divider: iterative radix-2 restoring divider for signed/unsigned DIV/MOD.
// Fixed WIDTH+2 cycle latency from accepted start to the one-cycle done pulse.
module multi_cycle_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_op,
  input  logic             start,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  rem_q, rem_d, dvd_q, dvd_d, div_q, div_d, a_q, a_d;
  logic [WIDTH-1:0]  quotient_q, quotient_d, remainder_q, remainder_d;
  logic              neg_q_q, neg_q_d, neg_r_q, neg_r_d, zero_q, zero_d, ovf_q, ovf_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              accept, a_neg, b_neg, ge;
  logic [WIDTH-1:0]  a_abs, b_abs, q_fix, r_fix;
  logic [WIDTH:0]    shifted, diff;
  assign accept = start & ~busy_q & (state_q == IDLE);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      div_q       <= '0;
      a_q         <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      div_q       <= div_d;
      a_q         <= a_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (accept ? CALC : IDLE) :
              (state_q == CALC) ? ((count_q == CW'(1)) ? FIX : CALC) : IDLE;
  end
  always_comb begin
    a_neg   = signed_op & a[WIDTH-1];
    b_neg   = signed_op & b[WIDTH-1];
    a_abs   = a_neg ? -a : a;
    b_abs   = b_neg ? -b : b;
    // The quotient bits shift into dvd_q as the dividend bits shift out.
    shifted = {rem_q, dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, div_q};
    ge      = ~diff[WIDTH];
    q_fix   = zero_q ? '1 : ovf_q ? MIN : neg_q_q ? -dvd_q : dvd_q;
    r_fix   = zero_q ? a_q : ovf_q ? '0 : neg_r_q ? -rem_q : rem_q;
    count_d = accept ? CW'(WIDTH) : (state_q == CALC) ? count_q - CW'(1) : count_q;
    rem_d   = accept ? '0 : (state_q == CALC) ? (ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0]) : rem_q;
    dvd_d   = accept ? a_abs : (state_q == CALC) ? {dvd_q[WIDTH-2:0], ge} : dvd_q;
    div_d   = accept ? b_abs : div_q;
    a_d     = accept ? a : a_q;
    neg_q_d = accept ? a_neg ^ b_neg : neg_q_q;
    neg_r_d = accept ? a_neg : neg_r_q;
    zero_d  = accept ? (b == '0) : zero_q;
    ovf_d   = accept ? (signed_op & (a == MIN) & (b == '1)) : ovf_q;
    quotient_d  = (state_q == FIX) ? q_fix : quotient_q;
    remainder_d = (state_q == FIX) ? r_fix : remainder_q;
    busy_d  = accept ? 1'b1 : done_q ? 1'b0 : busy_q;
    done_d  = (state_q == FIX);
  end
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_multi_cycle_divider.sv
// tb_multi_cycle_divider: scoreboard bench for the iterative divider (WIDTH=32).
module tb_multi_cycle_divider;
  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, signed_op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [31:0] quotient, remainder;
  logic        busy, done;
  int          total = 0, bad = 0;
  logic [63:0] sb_q[$];

  multi_cycle_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .b(b), .signed_op(signed_op), .start(start),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic signed [31:0] sx, sy;
    sx = x;
    sy = y;
    if (y == 32'h0) return {32'hFFFF_FFFF, x};
    if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    if (s) return {32'(sx / sy), 32'(sx % sy)};
    return {x / y, x % y};
  endfunction

  task automatic run_op(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic [63:0] expv);
    int lat, busy_cnt;
    bit seen;
    logic [63:0] e;
    @(posedge clk); #1;
    a = ta; b = tb_; signed_op = ts; start = 1'b1;
    sb_q.push_back(expv);
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; signed_op = ~ts;
    lat = 1; busy_cnt = 0; seen = 0;
    while (!seen && lat < 100) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1;
        e = sb_q.pop_front();
        total++; if (quotient !== e[63:32]) begin bad++; $display("FAIL %s quotient got=%h exp=%h", name, quotient, e[63:32]); end
        total++; if (remainder !== e[31:0]) begin bad++; $display("FAIL %s remainder got=%h exp=%h", name, remainder, e[31:0]); end
        total++; if (lat !== 34) begin bad++; $display("FAIL %s latency got=%0d exp=34", name, lat); end
        total++; if (busy_cnt !== 34) begin bad++; $display("FAIL %s busy_cycles got=%0d exp=34", name, busy_cnt); end
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!seen) begin total++; bad++; $display("FAIL %s timeout no done got=0 exp=1", name); sb_q.delete(); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL %s post_done busy=%b done=%b exp=0,0", name, busy, done); end
  endtask

  task automatic test_reset;
    #2;
    total++; if ({quotient, remainder, busy, done} !== 66'h0) begin bad++; $display("FAIL reset_state got q=%h r=%h busy=%b done=%b exp=0", quotient, remainder, busy, done); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_unsigned;
    run_op("unsigned_100_7", 32'd100, 32'd7, 1'b0, {32'd14, 32'd2});
    run_op("unsigned_max_3", 32'hFFFF_FFFF, 32'd3, 1'b0, {32'h5555_5555, 32'd0});
    run_op("unsigned_small_big", 32'd5, 32'd9, 1'b0, {32'd0, 32'd5});
  endtask

  task automatic test_signed;
    run_op("signed_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
    run_op("signed_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, {32'hFFFF_FFFD, 32'd1});
    run_op("signed_m7_m2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, {32'd3, 32'hFFFF_FFFF});
  endtask

  task automatic test_div_zero;
    run_op("divzero_unsigned", 32'h1234, 32'h0, 1'b0, {32'hFFFF_FFFF, 32'h1234});
    run_op("divzero_signed", 32'h1234, 32'h0, 1'b1, {32'hFFFF_FFFF, 32'h1234});
    run_op("divzero_signed_neg", 32'hFFFF_FF00, 32'h0, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FF00});
  endtask

  task automatic test_overflow;
    run_op("ovf_signed", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'h8000_0000, 32'h0});
    run_op("ovf_unsigned", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, {32'h0, 32'h8000_0000});
    run_op("min_div_1", 32'h8000_0000, 32'd1, 1'b1, {32'h8000_0000, 32'h0});
  endtask

  task automatic test_random;
    logic [31:0] x, y;
    logic s;
    for (int i = 0; i < 8; i++) begin
      x = $urandom;
      y = (i % 2) ? $urandom_range(1, 300) : $urandom;
      s = i[0] ^ i[1];
      run_op("random", x, y, s, model(x, y, s));
    end
  endtask

  task automatic test_back_to_back;
    int last_acc, n_acc, n_done, w;
    logic [63:0] e;
    last_acc = -1; n_acc = 0; n_done = 0;
    for (int c = 0; c < 107; c++) begin
      if (done) begin
        n_done++;
        total++;
        if (sb_q.size() == 0) begin bad++; $display("FAIL b2b unexpected done got=1 exp=0"); end
        else begin
          e = sb_q.pop_front();
          if ({quotient, remainder} !== e) begin bad++; $display("FAIL b2b result got=%h_%h exp=%h_%h", quotient, remainder, e[63:32], e[31:0]); end
        end
      end
      a = $urandom; b = (c % 3 == 0) ? 32'h0 : $urandom_range(1, 1000); signed_op = $urandom; start = 1'b1;
      if (!busy) begin
        sb_q.push_back(model(a, b, signed_op));
        n_acc++;
        if (last_acc >= 0) begin total++; if (c - last_acc !== 35) begin bad++; $display("FAIL b2b interval got=%0d exp=35", c - last_acc); end end
        last_acc = c;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    w = 0;
    while (!done && w < 50) begin @(posedge clk); #1; w++; end
    total++;
    if (!done) begin bad++; $display("FAIL b2b drain timeout got=0 exp=1"); sb_q.delete(); end
    else begin
      n_done++;
      e = sb_q.pop_front();
      if ({quotient, remainder} !== e) begin bad++; $display("FAIL b2b last result got=%h_%h exp=%h_%h", quotient, remainder, e[63:32], e[31:0]); end
    end
    total++; if (n_acc !== 4 || n_done !== 4) begin bad++; $display("FAIL b2b counts got acc=%0d done=%0d exp=4,4", n_acc, n_done); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset;
    int dones;
    run_op("pre_reset", 32'd100, 32'd7, 1'b0, {32'd14, 32'd2});
    @(posedge clk); #1;
    a = 32'd500; b = 32'd3; signed_op = 1'b0; start = 1'b1;
    sb_q.push_back({32'd166, 32'd2});
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    total++; if ({quotient, remainder, busy, done} !== 66'h0) begin bad++; $display("FAIL async_reset got q=%h r=%h busy=%b done=%b exp=0", quotient, remainder, busy, done); end
    sb_q.delete();
    dones = 0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done) dones++; end
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) dones++; end
    total++; if (dones !== 0) begin bad++; $display("FAIL reset_discard done_pulses got=%0d exp=0", dones); end
    run_op("post_reset", 32'd1000, 32'd33, 1'b0, {32'd30, 32'd10});
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_div_zero;
    test_overflow;
    test_random;
    test_back_to_back;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
